// File: rtl/icache_tag_array.sv
// N-way set-associative icache tag array: parallel tag compare, first-invalid /
// round-robin victim choice, and a one-set-per-cycle invalidate-all sweep.
module icache_tag_array #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 256,
  parameter int unsigned TAG_W = 20,
  parameter int unsigned SET_W = 8,
  parameter int unsigned WAY_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lookup_valid_i,
  input  logic [SET_W-1:0] lookup_set_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             lookup_done_o,
  output logic             hit_o,
  output logic [WAYS-1:0]  hit_way_o,
  output logic [WAY_W-1:0] victim_way_o,
  input  logic             fill_i,
  input  logic [SET_W-1:0] fill_set_i,
  input  logic [WAY_W-1:0] fill_way_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  input  logic             inv_all_i,
  output logic             busy_o
);

  typedef enum logic {StIdle, StSweep} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [SET_W-1:0] r_cnt;

  // Tag contents are never reset; valid bits and rr pointers are cleared by the sweep.
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAY_W-1:0] r_rr    [SETS];

  logic             w_idle;
  logic             w_fill_en;
  logic             w_lookup_en;
  logic             w_fill_same;
  logic [WAY_W-1:0] w_rr_nxt;
  logic [WAY_W-1:0] w_rr;
  logic [WAYS-1:0]  w_vld;
  logic [WAYS-1:0]  w_hit_way;
  logic [WAY_W-1:0] w_victim;

  assign w_idle      = (r_state == StIdle);
  assign w_fill_en   = fill_i && w_idle;
  assign w_lookup_en = lookup_valid_i && w_idle;
  assign w_fill_same = w_fill_en && (fill_set_i == lookup_set_i);
  assign w_rr_nxt    = (fill_way_i == WAY_W'(WAYS - 1)) ? '0 : fill_way_i + WAY_W'(1);

  // FSM state register and sweep counter; reset restarts the sweep from set 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= StSweep;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StSweep) begin
        r_cnt <= r_cnt + SET_W'(1);
      end else if (inv_all_i) begin
        r_cnt <= '0;
      end
    end
  end

  // FSM next state: inv_all_i only honoured from idle, so a sweep never restarts.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (inv_all_i) w_state_nxt = StSweep;
      StSweep: if (r_cnt == SET_W'(SETS - 1)) w_state_nxt = StIdle;
      default: w_state_nxt = StSweep;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_o = (r_state == StSweep);
  end

  // Array writes: fill in idle, per-set clear while sweeping.
  always_ff @(posedge clk_i) begin
    if (w_fill_en) begin
      r_tag[fill_set_i][fill_way_i]   <= fill_tag_i;
      r_valid[fill_set_i][fill_way_i] <= 1'b1;
      r_rr[fill_set_i]                <= w_rr_nxt;
    end
    if (r_state == StSweep) begin
      r_valid[r_cnt] <= '0;
      r_rr[r_cnt]    <= '0;
    end
  end

  // Lookup compare against post-fill state so a same-cycle fill is visible (write-first).
  always_comb begin
    w_vld     = r_valid[lookup_set_i];
    w_hit_way = '0;
    w_rr      = w_fill_same ? w_rr_nxt : r_rr[lookup_set_i];
    for (int w = 0; w < WAYS; w++) begin
      logic             l_bypass;
      logic [TAG_W-1:0] l_tag;
      l_bypass = w_fill_same && (fill_way_i == WAY_W'(w));
      l_tag    = l_bypass ? fill_tag_i : r_tag[lookup_set_i][w];
      if (l_bypass) w_vld[w] = 1'b1;
      w_hit_way[w] = w_vld[w] && (l_tag == lookup_tag_i);
    end
  end

  // Victim: lowest-index invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    w_victim = w_rr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_vld[w]) w_victim = WAY_W'(w);
    end
    if (WAYS == 1) w_victim = '0;
  end

  // Registered results; they hold between lookups.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lookup_done_o <= 1'b0;
      hit_o         <= 1'b0;
      hit_way_o     <= '0;
      victim_way_o  <= '0;
    end else begin
      lookup_done_o <= w_lookup_en;
      if (w_lookup_en) begin
        hit_o        <= |w_hit_way;
        hit_way_o    <= w_hit_way;
        victim_way_o <= w_victim;
      end
    end
  end

endmodule

// File: tb/tb_icache_tag_array.sv
// Scoreboard bench for icache_tag_array (2 ways, 256 sets, 20-bit tags).
module tb_icache_tag_array;

  logic        clk;
  logic        rst_n;
  logic        lookup_valid;
  logic [7:0]  lookup_set;
  logic [19:0] lookup_tag;
  logic        lookup_done;
  logic        hit;
  logic [1:0]  hit_way;
  logic [0:0]  victim_way;
  logic        fill;
  logic [7:0]  fill_set;
  logic [0:0]  fill_way;
  logic [19:0] fill_tag;
  logic        inv_all;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Expected {hit, hit_way[1:0], victim}.
  logic [3:0] exp_q[$];

  icache_tag_array #(
    .WAYS(2), .SETS(256), .TAG_W(20), .SET_W(8), .WAY_W(1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .lookup_valid_i(lookup_valid),
    .lookup_set_i  (lookup_set),
    .lookup_tag_i  (lookup_tag),
    .lookup_done_o (lookup_done),
    .hit_o         (hit),
    .hit_way_o     (hit_way),
    .victim_way_o  (victim_way),
    .fill_i        (fill),
    .fill_set_i    (fill_set),
    .fill_way_i    (fill_way),
    .fill_tag_i    (fill_tag),
    .inv_all_i     (inv_all),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every lookup_done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && lookup_done) begin
      logic [3:0] got;
      logic [3:0] exp;
      got = {hit, hit_way, victim_way};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_done got=%h required=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_errors++;
          $display("FAIL lookup_result got=%h required=%h", got, exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    lookup_valid = 1'b0;
    fill         = 1'b0;
    inv_all      = 1'b0;
  endtask

  task automatic drive_fill(input logic [7:0] s, input logic w, input logic [19:0] t);
    fill     = 1'b1;
    fill_set = s;
    fill_way = w;
    fill_tag = t;
  endtask

  task automatic drive_lookup(input logic [7:0] s, input logic [19:0] t);
    lookup_valid = 1'b1;
    lookup_set   = s;
    lookup_tag   = t;
  endtask

  task automatic expect_lookup(input logic h, input logic [1:0] hw, input logic v);
    exp_q.push_back({h, hw, v});
  endtask

  // Counts cycles busy stays high; optionally injects a dropped fill+lookup at cycle 200.
  task automatic count_busy(input string name, input bool_inject);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      if (bool_inject && n == 200) begin
        drive_fill(8'd0, 1'b1, 20'h00003);
        drive_lookup(8'd0, 20'h00003);
      end
      step();
      n++;
    end
    check(name, n, 256);
  endtask

  initial begin
    rst_n        = 1'b1;
    lookup_valid = 1'b0;
    lookup_set   = '0;
    lookup_tag   = '0;
    fill         = 1'b0;
    fill_set     = '0;
    fill_way     = '0;
    fill_tag     = '0;
    inv_all      = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", busy, 1);
    check("rst_done", lookup_done, 0);
    check("rst_outs", {hit, hit_way, victim_way}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: sweep after reset, with a dropped lookup at sweep cycle 10
    begin
      int n;
      n = 0;
      while (busy && n < 1000) begin
        if (n == 10) drive_lookup(8'd3, 20'h0);
        step();
        n++;
        if (n == 11) check("sweep_lookup_dropped", lookup_done, 0);
      end
      check("sweep_len_reset", n, 256);
    end

    // 2: fill then hit
    drive_fill(8'd5, 1'b0, 20'hABCDE);
    step();
    drive_lookup(8'd5, 20'hABCDE);
    expect_lookup(1'b1, 2'b01, 1'b1);
    step();
    check("done_pulse", lookup_done, 1);
    step();
    check("done_one_cycle", lookup_done, 0);
    check("outputs_hold", {hit, hit_way}, 3'b101);

    // 3: miss picks invalid way 1; after filling way 1 rr wraps to 0
    drive_lookup(8'd5, 20'h12345);
    expect_lookup(1'b0, 2'b00, 1'b1);
    step();
    drive_fill(8'd5, 1'b1, 20'h11111);
    step();
    drive_lookup(8'd5, 20'h12345);
    expect_lookup(1'b0, 2'b00, 1'b0);
    step();

    // 4: same-cycle fill and lookup see post-fill state
    drive_fill(8'd9, 1'b1, 20'h00FFF);
    drive_lookup(8'd9, 20'h00FFF);
    expect_lookup(1'b1, 2'b10, 1'b0);
    step();

    // 5: fill boundary sets, confirm, sweep, confirm cleared
    drive_fill(8'd0, 1'b0, 20'h00001);
    step();
    drive_fill(8'd255, 1'b1, 20'h00002);
    step();
    drive_lookup(8'd0, 20'h00001);
    expect_lookup(1'b1, 2'b01, 1'b1);
    step();
    drive_lookup(8'd255, 20'h00002);
    expect_lookup(1'b1, 2'b10, 1'b0);
    step();
    inv_all = 1'b1;
    step();
    check("inv_busy_rise", busy, 1);
    count_busy("sweep_len_inv", 1'b1);
    drive_lookup(8'd0, 20'h00001);
    expect_lookup(1'b0, 2'b00, 1'b0);
    step();
    drive_lookup(8'd0, 20'h00003);
    expect_lookup(1'b0, 2'b00, 1'b0);
    step();
    drive_lookup(8'd255, 20'h00002);
    expect_lookup(1'b0, 2'b00, 1'b0);
    step();

    // 6: reset mid-sweep, with a hit held on the outputs beforehand
    drive_fill(8'd9, 1'b1, 20'h00FFF);
    step();
    drive_lookup(8'd9, 20'h00FFF);
    expect_lookup(1'b1, 2'b10, 1'b0);
    step();
    step();
    inv_all = 1'b1;
    step();
    repeat (100) step();
    check("mid_sweep_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {lookup_done, hit, hit_way, victim_way}, 0);
    check("midrst_busy", busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy("sweep_len_rerst", 1'b0);
    drive_lookup(8'd9, 20'h00FFF);
    expect_lookup(1'b0, 2'b00, 1'b0);
    step();

    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
